// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller: write-through, no-write-allocate, whole-line refill on a read miss.
// Drives external valid/tag/data memories, all with 1-cycle registered reads, plus a main-memory request port.
module dm_cache_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_LENGTH   = 8,
  parameter int TAG_LENGTH     = ADDR_WIDTH - INDEX_LENGTH - $clog2(WORDS_PER_LINE) - $clog2(DATA_WIDTH/8)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cpu_req_valid,
  output logic                              cpu_req_ready,
  input  logic                              cpu_req_we,
  input  logic [ADDR_WIDTH-1:0]             cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]             cpu_req_wdata,
  output logic                              cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]             cpu_resp_rdata,
  output logic                              vm_write,
  output logic [INDEX_LENGTH-1:0]           vm_index,
  input  logic                              vm_valid,
  output logic                              tm_write,
  output logic [INDEX_LENGTH-1:0]           tm_index,
  output logic [TAG_LENGTH-1:0]             tm_wtag,
  input  logic [TAG_LENGTH-1:0]             tm_rtag,
  output logic                              dm_write,
  output logic [INDEX_LENGTH-1:0]           dm_index,
  output logic [$clog2(WORDS_PER_LINE)-1:0] dm_word,
  output logic [DATA_WIDTH-1:0]             dm_wdata,
  input  logic [DATA_WIDTH-1:0]             dm_rdata,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_req_we,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  output logic [DATA_WIDTH-1:0]             mem_req_wdata,
  input  logic                              mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_resp_rdata
);

  localparam int BO  = $clog2(DATA_WIDTH/8);
  localparam int WB  = $clog2(WORDS_PER_LINE);
  localparam int OFF = WB + BO;
  localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP, WR_MEM} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   resp_q, resp_d;
  logic [WB-1:0]           cnt_q, cnt_d;

  logic [TAG_LENGTH-1:0]   lat_tag;
  logic [INDEX_LENGTH-1:0] lat_index;
  logic [WB-1:0]           lat_word;
  logic                    hit;

  assign lat_tag   = addr_q[ADDR_WIDTH-1 -: TAG_LENGTH];
  assign lat_index = addr_q[OFF +: INDEX_LENGTH];
  assign lat_word  = addr_q[BO +: WB];
  assign hit       = vm_valid && (tm_rtag == lat_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    resp_d         = resp_q;
    cnt_d          = cnt_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    vm_write       = 1'b0;
    tm_write       = 1'b0;
    dm_write       = 1'b0;
    vm_index       = lat_index;
    tm_index       = lat_index;
    dm_index       = lat_index;
    dm_word        = lat_word;
    tm_wtag        = '0;
    dm_wdata       = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;

    case (state_q)
      // The memories are indexed straight from the incoming address so their reads land in LOOKUP.
      IDLE: begin
        cpu_req_ready = 1'b1;
        vm_index      = cpu_req_addr[OFF +: INDEX_LENGTH];
        tm_index      = cpu_req_addr[OFF +: INDEX_LENGTH];
        dm_index      = cpu_req_addr[OFF +: INDEX_LENGTH];
        dm_word       = cpu_req_addr[BO +: WB];
        if (cpu_req_valid) begin
          addr_d  = cpu_req_addr;
          we_d    = cpu_req_we;
          wdata_d = cpu_req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          if (hit) begin
            dm_write = 1'b1;
            dm_wdata = wdata_q;
          end
          state_d = WR_MEM;
        end else if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_rdata = dm_rdata;
          state_d        = IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      // Valid and tag are written only with the last beat, so a partial line never looks valid.
      REFILL: begin
        dm_word = cnt_q;
        if (mem_resp_valid) begin
          dm_write = 1'b1;
          dm_wdata = mem_resp_rdata;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == lat_word) resp_d = mem_resp_rdata;
          if (cnt_q == LAST_WORD) begin
            tm_write = 1'b1;
            tm_wtag  = lat_tag;
            vm_write = 1'b1;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = resp_q;
        state_d        = IDLE;
      end
      WR_MEM: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        if (mem_req_ready) begin
          cpu_resp_valid = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed vector table, reset corner cases and randomized traffic
// checked against a line-level cache/main-memory model.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        vm_write, vm_valid;
  logic [7:0]  vm_index, tm_index, dm_index;
  logic        tm_write;
  logic [19:0] tm_wtag, tm_rtag;
  logic        dm_write;
  logic [1:0]  dm_word;
  logic [31:0] dm_wdata, dm_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .vm_write(vm_write), .vm_index(vm_index), .vm_valid(vm_valid),
    .tm_write(tm_write), .tm_index(tm_index), .tm_wtag(tm_wtag), .tm_rtag(tm_rtag),
    .dm_write(dm_write), .dm_index(dm_index), .dm_word(dm_word), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  // Valid, tag and data memories with registered reads; the valid memory shares the controller reset.
  logic        valid_arr [256];
  logic [19:0] tag_arr   [256];
  logic [31:0] data_arr  [256][4];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) valid_arr[i] <= 1'b0;
      vm_valid <= 1'b0;
    end else if (vm_write) valid_arr[vm_index] <= 1'b1;
    else vm_valid <= valid_arr[vm_index];
    if (tm_write) tag_arr[tm_index] <= tm_wtag;
    else tm_rtag <= tag_arr[tm_index];
    if (dm_write) data_arr[dm_index][dm_word] <= dm_wdata;
    dm_rdata <= data_arr[dm_index][dm_word];
  end

  // Reference model: which lines the cache holds, and the word-level contents of main memory.
  bit          ref_valid [256];
  logic [19:0] ref_tag   [256];
  logic [31:0] mainmem [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mainmem.exists(a)) return mainmem[a];
    return ~a;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic doReset(input int n, input bit late_beats);
    @(negedge clk);
    reset = 1'b1;
    cpu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      mem_resp_valid = late_beats;
      mem_resp_rdata = $urandom;
      #1;
      checkOutput("rst_strobes", {dm_write, vm_write, tm_write, mem_req_valid}, 4'b0);
      checkOutput("rst_resp", cpu_resp_valid, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    mem_resp_valid = late_beats;
    #1;
    checkOutput("post_rst_ready", cpu_req_ready, 1'b1);
    checkOutput("post_rst_strobes", {dm_write, vm_write, tm_write, mem_req_valid, cpu_resp_valid}, 5'b0);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
  endtask

  // One CPU transaction with a reactive main memory. rw = cycles of mem_req_valid before ready,
  // gap_beat = beat after which one idle cycle is inserted, rst_beat = abandon after this beat.
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input int rw, input int gap_beat, input int rst_beat, input bit rnd,
                               input bit exp_hit, input logic [31:0] exp_rdata,
                               output int lat, output logic [31:0] rdata);
    logic [7:0]  idx = addr[11:4];
    logic [19:0] tag = addr[31:12];
    logic [31:0] base = {addr[31:4], 4'h0};
    logic [31:0] req_addr = '0, req_wdata = '0, beat_data = '0;
    bit req_we = 0, first_seen = 0, unstable = 0, got = 0, refilling = 0, gap_pending = 0, aborted = 0;
    int cyc = 0, beat = 0, gaps = 0, nreq = 0, dm_cnt = 0, vm_cnt = 0, tm_cnt = 0;
    int vm_beat = -1, bad = 0, wait_cnt = 0, exp_lat;
    lat = -1;
    rdata = 'x;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    checkOutput("req_ready", cpu_req_ready, 1'b1);
    checkOutput("resp_idle", cpu_resp_valid, 1'b0);
    while (!got && !aborted && cyc < 100) begin
      @(negedge clk);
      cyc++;
      cpu_req_valid = 1'b0; cpu_req_we = 1'($urandom); cpu_req_addr = $urandom; cpu_req_wdata = $urandom;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
      #1;
      if (mem_req_valid) begin
        if (!first_seen) begin
          first_seen = 1; req_addr = mem_req_addr; req_we = mem_req_we; req_wdata = mem_req_wdata;
        end else if (mem_req_addr !== req_addr || mem_req_we !== req_we || mem_req_wdata !== req_wdata)
          unstable = 1;
        if (wait_cnt >= rw) mem_req_ready = 1'b1;
        else wait_cnt++;
      end
      if (refilling) begin
        if (gap_pending || (rnd && $urandom_range(0, 3) == 0)) begin
          gap_pending = 0;
          gaps++;
        end else begin
          beat_data = mem_read(base + 32'(beat * 4));
          mem_resp_valid = 1'b1;
          mem_resp_rdata = beat_data;
          beat++;
          if (beat == gap_beat + 1 && beat < 4) gap_pending = 1;
        end
      end else if (rnd) mem_resp_valid = 1'($urandom_range(0, 1));
      #1;
      if (dm_write) begin
        dm_cnt++;
        if (dm_index !== idx) bad++;
        if (refilling && mem_resp_valid) begin
          if (dm_word !== 2'(beat - 1) || dm_wdata !== beat_data) bad++;
        end else if (cyc == 1) begin
          if (dm_word !== addr[3:2] || dm_wdata !== wdata) bad++;
        end else bad++;
      end
      if (vm_write) begin
        vm_cnt++;
        vm_beat = beat;
        if (vm_index !== idx) bad++;
      end
      if (tm_write) begin
        tm_cnt++;
        if (tm_index !== idx || tm_wtag !== tag) bad++;
      end
      if (refilling && beat == 4) refilling = 0;
      if (cpu_resp_valid) begin
        got = 1; rdata = cpu_resp_rdata; lat = cyc;
      end
      if (mem_req_valid && mem_req_ready) begin
        nreq++;
        if (!mem_req_we) begin refilling = 1; beat = 0; end
      end
      if (rst_beat >= 0 && beat == rst_beat + 1) aborted = 1;
    end
    if (aborted) begin
      checkOutput("abort_no_resp", got, 1'b0);
      checkOutput("abort_strobes", bad, 0);
      return;
    end
    checkOutput("resp_seen", got, 1'b1);
    exp_lat = we ? (1 + rw + 1) : (exp_hit ? 1 : (1 + rw + 1 + 4 + gaps + 1));
    checkOutput("latency", lat, exp_lat);
    checkOutput("rdata", rdata, exp_rdata);
    checkOutput("strobe_fields", bad, 0);
    checkOutput("req_stable", unstable, 1'b0);
    if (we) begin
      checkOutput("st_nreq", nreq, 1);
      checkOutput("st_req", {req_we, req_addr, req_wdata}, {1'b1, addr, wdata});
      checkOutput("st_dm_cnt", dm_cnt, exp_hit ? 1 : 0);
      checkOutput("st_vm_tm", vm_cnt + tm_cnt, 0);
      mainmem[{addr[31:2], 2'b00}] = wdata;
    end else if (exp_hit) begin
      checkOutput("hit_nreq", nreq, 0);
      checkOutput("hit_writes", dm_cnt + vm_cnt + tm_cnt, 0);
    end else begin
      checkOutput("miss_nreq", nreq, 1);
      checkOutput("miss_req", {req_we, req_addr}, {1'b0, base});
      checkOutput("miss_dm_cnt", dm_cnt, 4);
      checkOutput("miss_vm_tm", {vm_cnt, tm_cnt}, {32'd1, 32'd1});
      checkOutput("miss_vm_beat", vm_beat, 4);
      ref_valid[idx] = 1'b1;
      ref_tag[idx] = tag;
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rw;
    int          gap;
    bit          hit;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat;
    logic [31:0] rd;
    vecs[0] = '{0, 32'h0000_0104, 32'h0,         0, 1, 0, 32'hA1,        8};
    vecs[1] = '{0, 32'h0000_010C, 32'h0,         0, -1, 1, 32'hA3,       1};
    vecs[2] = '{0, 32'h0001_0104, 32'h0,         0, -1, 0, 32'hFFFE_FEFB, 7};
    vecs[3] = '{0, 32'h0000_0104, 32'h0,         0, -1, 0, 32'hA1,       7};
    vecs[4] = '{0, 32'h0001_0100, 32'h0,         0, -1, 0, 32'hFFFE_FEFF, 7};
    vecs[5] = '{1, 32'h0001_0108, 32'hDEAD_BEEF, 3, -1, 1, 32'h0,        5};
    vecs[6] = '{0, 32'h0001_0108, 32'h0,         0, -1, 1, 32'hDEAD_BEEF, 1};
    vecs[7] = '{1, 32'h0002_0000, 32'h1234_5678, 1, -1, 0, 32'h0,        3};
    vecs[8] = '{0, 32'h0002_0000, 32'h0,         0, -1, 0, 32'h1234_5678, 7};
    mainmem[32'h100] = 32'hA0;
    mainmem[32'h104] = 32'hA1;
    mainmem[32'h108] = 32'hA2;
    mainmem[32'h10C] = 32'hA3;

    reset = 1'b1;
    cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    doReset(3, 1'b0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].gap, -1, 1'b0,
                    vecs[i].hit, vecs[i].rdata, lat, rd);
      checkOutput("vec_lat", lat, vecs[i].lat);
      checkOutput("vec_rdata", rd, vecs[i].rdata);
    end

    doReset(3, 1'b0);
    applyStimulus(0, 32'h0000_0104, 0, 0, -1, -1, 1'b0, 1'b0, 32'hA1, lat, rd);

    applyStimulus(0, 32'h0000_0204, 0, 0, -1, 2, 1'b0, 1'b0, 32'h0, lat, rd);
    doReset(3, 1'b1);
    applyStimulus(0, 32'h0000_0204, 0, 0, -1, -1, 1'b0, 1'b0, ~32'h0000_0204, lat, rd);

    for (int n = 0; n < 150; n++) begin
      logic [19:0] t;
      logic [7:0]  ix;
      logic [31:0] a;
      bit          w;
      t  = 20'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: ix = 8'h10;
        1: ix = 8'h11;
        default: ix = 8'h33;
      endcase
      a = {t, ix, 2'($urandom_range(0, 3)), 2'b00};
      w = ($urandom_range(0, 9) < 3);
      applyStimulus(w, a, $urandom, $urandom_range(0, 3), -1, -1, 1'b1,
                    ref_valid[ix] && (ref_tag[ix] == t), w ? 32'h0 : mem_read(a), lat, rd);
    end

    @(negedge clk);
    #1;
    checkOutput("final_resp", cpu_resp_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
